// File: rtl/pig_force_gen.sv
// Pig push-force generator: accumulates bird/pig overlap per frame and, after each
// vsync, produces a clamped signed push force with a post-hit cooldown.
module pig_force_gen #(
   parameter int         K_SHIFT  = 2,
   parameter logic [9:0] HIT_TH   = 10'd8,
   parameter logic [16:0] FMAX    = 17'd2048,
   parameter logic [2:0] COOLDOWN = 3'd2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        pig,
   input  logic        bird,
   input  logic [3:0]  pig_dir,
   input  logic [16:0] bird_vx,
   input  logic [16:0] bird_vy,
   output logic [16:0] pig_force_x,
   output logic [16:0] pig_force_y,
   output logic        force_valid,
   output logic        hit,
   output logic [9:0]  overlap_cnt
);

   // state | meaning
   // ACC   | accumulate pixels, wait for vsync
   // SNAP  | form pixel imbalance and hit flag from the snapshot
   // CALC  | add bird-velocity transfer term
   // SAT   | clamp, apply cooldown, register outputs
   localparam logic [1:0] ST_ACC  = 2'd0;
   localparam logic [1:0] ST_SNAP = 2'd1;
   localparam logic [1:0] ST_CALC = 2'd2;
   localparam logic [1:0] ST_SAT  = 2'd3;

   localparam logic signed [17:0] FMAX_S = $signed({1'b0, FMAX});

   function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic en);
      return (en && (v != 10'd1023)) ? v + 10'd1 : v;
   endfunction

   function automatic logic [16:0] clamp(input logic signed [17:0] v);
      if (v > FMAX_S)       return FMAX;
      else if (v < -FMAX_S) return (~FMAX) + 17'd1;
      else                  return v[16:0];
   endfunction

   logic [1:0]  state_q, state_d;
   logic [9:0]  ovl_q, ovl_d, cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
   logic [9:0]  cnt_u_q, cnt_u_d, cnt_d_q, cnt_d_d;
   logic [9:0]  snap_ovl_q, snap_ovl_d, snap_l_q, snap_l_d, snap_r_q, snap_r_d;
   logic [9:0]  snap_u_q, snap_u_d, snap_d_q, snap_d_d;
   logic signed [17:0] dx_q, dx_d, dy_q, dy_d, fx_q, fx_d, fy_q, fy_d;
   logic        is_hit_q, is_hit_d;
   logic [2:0]  cd_q, cd_d;
   logic [16:0] force_x_q, force_x_d, force_y_q, force_y_d;
   logic        valid_q, valid_d, hit_q, hit_d;
   logic [9:0]  ovl_out_q, ovl_out_d;

   logic ovl_pix, inc_l, inc_r, inc_u, inc_d;
   logic signed [17:0] vx_ext, vy_ext;

   assign ovl_pix = pig & bird;
   assign inc_l   = ovl_pix & ~pig_dir[3] & ~pig_dir[1];
   assign inc_r   = ovl_pix & ~pig_dir[3] &  pig_dir[1];
   assign inc_u   = ovl_pix & ~pig_dir[2] & ~pig_dir[0];
   assign inc_d   = ovl_pix & ~pig_dir[2] &  pig_dir[0];
   assign vx_ext  = $signed({bird_vx[16], bird_vx});
   assign vy_ext  = $signed({bird_vy[16], bird_vy});

   always_comb begin
      state_d    = state_q;
      snap_ovl_d = snap_ovl_q;
      snap_l_d   = snap_l_q;
      snap_r_d   = snap_r_q;
      snap_u_d   = snap_u_q;
      snap_d_d   = snap_d_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      fx_d       = fx_q;
      fy_d       = fy_q;
      is_hit_d   = is_hit_q;
      cd_d       = cd_q;
      force_x_d  = force_x_q;
      force_y_d  = force_y_q;
      hit_d      = hit_q;
      ovl_out_d  = ovl_out_q;
      valid_d    = 1'b0;

      // vsync snapshots in any state; the coincident pixel opens the new frame
      if (vsync) begin
         snap_ovl_d = ovl_q;
         snap_l_d   = cnt_l_q;
         snap_r_d   = cnt_r_q;
         snap_u_d   = cnt_u_q;
         snap_d_d   = cnt_d_q;
         ovl_d      = {9'd0, ovl_pix};
         cnt_l_d    = {9'd0, inc_l};
         cnt_r_d    = {9'd0, inc_r};
         cnt_u_d    = {9'd0, inc_u};
         cnt_d_d    = {9'd0, inc_d};
      end else begin
         ovl_d   = sat_inc(ovl_q, ovl_pix);
         cnt_l_d = sat_inc(cnt_l_q, inc_l);
         cnt_r_d = sat_inc(cnt_r_q, inc_r);
         cnt_u_d = sat_inc(cnt_u_q, inc_u);
         cnt_d_d = sat_inc(cnt_d_q, inc_d);
      end

      case (state_q)
         ST_ACC: if (vsync) state_d = ST_SNAP;
         ST_SNAP: begin
            dx_d     = $signed({8'd0, snap_l_q}) - $signed({8'd0, snap_r_q});
            dy_d     = $signed({8'd0, snap_u_q}) - $signed({8'd0, snap_d_q});
            is_hit_d = (snap_ovl_q >= HIT_TH);
            state_d  = ST_CALC;
         end
         ST_CALC: begin
            fx_d    = (dx_q <<< K_SHIFT) + (is_hit_q ? (vx_ext >>> 1) : 18'sd0);
            fy_d    = (dy_q <<< K_SHIFT) + (is_hit_q ? (vy_ext >>> 1) : 18'sd0);
            state_d = ST_SAT;
         end
         default: begin
            if (cd_q != 3'd0) begin
               force_x_d = 17'd0;
               force_y_d = 17'd0;
               hit_d     = 1'b0;
               cd_d      = cd_q - 3'd1;
            end else begin
               force_x_d = clamp(fx_q);
               force_y_d = clamp(fy_q);
               hit_d     = is_hit_q;
               if (is_hit_q) cd_d = COOLDOWN;
            end
            ovl_out_d = snap_ovl_q;
            valid_d   = 1'b1;
            state_d   = ST_ACC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_ACC;
         ovl_q      <= '0;
         cnt_l_q    <= '0;
         cnt_r_q    <= '0;
         cnt_u_q    <= '0;
         cnt_d_q    <= '0;
         snap_ovl_q <= '0;
         snap_l_q   <= '0;
         snap_r_q   <= '0;
         snap_u_q   <= '0;
         snap_d_q   <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         fx_q       <= '0;
         fy_q       <= '0;
         is_hit_q   <= 1'b0;
         cd_q       <= '0;
         force_x_q  <= '0;
         force_y_q  <= '0;
         valid_q    <= 1'b0;
         hit_q      <= 1'b0;
         ovl_out_q  <= '0;
      end else begin
         state_q    <= state_d;
         ovl_q      <= ovl_d;
         cnt_l_q    <= cnt_l_d;
         cnt_r_q    <= cnt_r_d;
         cnt_u_q    <= cnt_u_d;
         cnt_d_q    <= cnt_d_d;
         snap_ovl_q <= snap_ovl_d;
         snap_l_q   <= snap_l_d;
         snap_r_q   <= snap_r_d;
         snap_u_q   <= snap_u_d;
         snap_d_q   <= snap_d_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         fx_q       <= fx_d;
         fy_q       <= fy_d;
         is_hit_q   <= is_hit_d;
         cd_q       <= cd_d;
         force_x_q  <= force_x_d;
         force_y_q  <= force_y_d;
         valid_q    <= valid_d;
         hit_q      <= hit_d;
         ovl_out_q  <= ovl_out_d;
      end
   end

   assign pig_force_x = force_x_q;
   assign pig_force_y = force_y_q;
   assign force_valid = valid_q;
   assign hit         = hit_q;
   assign overlap_cnt = ovl_out_q;

endmodule

// File: tb/tb_pig_force_gen.sv
// Directed bench for pig_force_gen: hand-computed forces for hit, sub-threshold,
// clamp, cooldown and reset scenarios; inputs change on the falling edge.
module tb_pig_force_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        vsync = 1'b0;
   logic        pig = 1'b0;
   logic        bird = 1'b0;
   logic [3:0]  pig_dir = 4'd0;
   logic [16:0] bird_vx = 17'd0;
   logic [16:0] bird_vy = 17'd0;
   logic [16:0] pig_force_x, pig_force_y;
   logic        force_valid, hit;
   logic [9:0]  overlap_cnt;

   int checks = 0;
   int errors = 0;

   pig_force_gen dut (
      .clk(clk), .rst(rst), .vsync(vsync), .pig(pig), .bird(bird),
      .pig_dir(pig_dir), .bird_vx(bird_vx), .bird_vy(bird_vy),
      .pig_force_x(pig_force_x), .pig_force_y(pig_force_y),
      .force_valid(force_valid), .hit(hit), .overlap_cnt(overlap_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_outs(input string tag, input logic [16:0] efx, input logic [16:0] efy,
                             input logic ehit, input logic [9:0] eovl);
      chk({tag, ".fx"},  pig_force_x, efx);
      chk({tag, ".fy"},  pig_force_y, efy);
      chk({tag, ".hit"}, 17'(hit), 17'(ehit));
      chk({tag, ".ovl"}, 17'(overlap_cnt), 17'(eovl));
   endtask

   // n overlap pixels with the given direction code, one per cycle
   task automatic feed(input int n, input logic [3:0] dir);
      pig_dir = dir;
      pig = 1'b1;
      bird = 1'b1;
      repeat (n) @(negedge clk);
      pig = 1'b0;
      bird = 1'b0;
   endtask

   // vsync pulse (optionally carrying an overlap pixel), then check the result at +3 edges
   task automatic frame(input string tag, input logic vpix, input logic [3:0] vdir,
                        input logic [16:0] efx, input logic [16:0] efy,
                        input logic ehit, input logic [9:0] eovl);
      vsync = 1'b1;
      pig = vpix;
      bird = vpix;
      pig_dir = vdir;
      @(negedge clk);
      vsync = 1'b0;
      pig = 1'b0;
      bird = 1'b0;
      repeat (2) @(negedge clk);
      chk({tag, ".early_valid"}, 17'(force_valid), 17'd0);
      @(negedge clk);
      chk({tag, ".valid"}, 17'(force_valid), 17'd1);
      check_outs(tag, efx, efy, ehit, eovl);
      @(negedge clk);
      chk({tag, ".valid_drop"}, 17'(force_valid), 17'd0);
   endtask

   initial begin
      // reset held with overlapping pixels toggling
      for (int i = 0; i < 6; i++) begin
         pig = i[0];
         bird = 1'b1;
         @(negedge clk);
         chk("rst.valid", 17'(force_valid), 17'd0);
         check_outs("rst", 17'd0, 17'd0, 1'b0, 10'd0);
      end
      pig = 1'b0;
      bird = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      frame("zero", 1'b0, 4'd0, 17'd0, 17'd0, 1'b0, 10'd0);

      // left/upper hit: dx=dy=20 -> 80, plus vx/2=64 on x
      bird_vx = 17'd128;
      bird_vy = 17'd0;
      feed(20, 4'b0000);
      frame("hit", 1'b0, 4'd0, 17'd144, 17'd80, 1'b1, 10'd20);
      feed(20, 4'b0000);
      frame("cool1", 1'b0, 4'd0, 17'd0, 17'd0, 1'b0, 10'd20);
      feed(20, 4'b0000);
      frame("cool2", 1'b0, 4'd0, 17'd0, 17'd0, 1'b0, 10'd20);
      feed(20, 4'b0000);
      frame("hit_again", 1'b0, 4'd0, 17'd144, 17'd80, 1'b1, 10'd20);
      frame("blank1", 1'b0, 4'd0, 17'd0, 17'd0, 1'b0, 10'd0);
      // the pixel riding on this vsync belongs to the next frame
      frame("blank2", 1'b1, 4'b0011, 17'd0, 17'd0, 1'b0, 10'd0);

      // sub-threshold: 5 right/down pixels, 2 in both centre bands, 7 overlap total
      feed(4, 4'b0011);
      feed(2, 4'b1100);
      frame("subth", 1'b0, 4'd0, 17'h1FFEC, 17'h1FFEC, 1'b0, 10'd7);

      // clamp with counter saturation: 1100 pixels left/down -> counts 1023
      bird_vx = 17'd4000;
      bird_vy = 17'h1E0C0;  // -8000
      feed(1100, 4'b0001);
      frame("clamp", 1'b0, 4'd0, 17'd2048, 17'h1F800, 1'b1, 10'd1023);

      // reset while in CALC; pixels fed before it must be discarded
      bird_vx = 17'd128;
      bird_vy = 17'd0;
      feed(20, 4'b0000);
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      pig = 1'b1;
      bird = 1'b1;
      @(negedge clk);
      pig = 1'b0;
      bird = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst.valid", 17'(force_valid), 17'd0);
      check_outs("midrst", 17'd0, 17'd0, 1'b0, 10'd0);
      repeat (2) @(negedge clk);
      chk("midrst.hold_valid", 17'(force_valid), 17'd0);
      rst = 1'b1;
      @(negedge clk);
      feed(20, 4'b0000);
      frame("post_rst", 1'b0, 4'd0, 17'd144, 17'd80, 1'b1, 10'd20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
